// File: rtl/spi_cmd_ctrl_if.sv
// rtl/spi_cmd_ctrl_if.sv - command/payload handshake bundle from the SPI front end
interface spi_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            cmd_word;
  logic [DATA_WIDTH-1:0] data_word;
  logic                  cmd_valid;

  modport master (output cmd_word, data_word, cmd_valid);
  modport slave  (input  cmd_word, data_word, cmd_valid);
endinterface

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - DDS channel command decoder with shadow/active registers (optional CMD_ERR_CNT_EN)
module spi_cmd_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  spi_cmd_ctrl_if.slave                cmd,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_phase_inc,
  output logic [NUM_CH*8-1:0]          ch_amp,
  output logic [NUM_CH*2-1:0]          ch_wave,
  output logic [NUM_CH-1:0]            ch_enable,
  output logic [NUM_CH-1:0]            phase_rst,
  output logic                         update_strobe
`ifdef CMD_ERR_CNT_EN
  ,
  output logic [7:0]                   err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

  state_t                       state;
  logic                         valid_q;
  logic [7:0]                   cmd_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [7:0]                   hold_cmd;
  logic [DATA_WIDTH-1:0]        hold_data;
  logic [NUM_CH*DATA_WIDTH-1:0] sh_phase;
  logic [NUM_CH*8-1:0]          sh_amp;
  logic [NUM_CH*2-1:0]          sh_wave;
  logic [3:0]                   opcode;
  logic [3:0]                   ch;
  logic                         ch_ok;
  logic                         reject;

  assign opcode = hold_cmd[7:4];
  assign ch     = hold_cmd[3:0];
  assign ch_ok  = ({1'b0, ch} < NUM_CH_L);

  // Input sample stage; deliberately not reset so a cmd_valid held through reset stays visible to WAIT_LOW
  always_ff @(posedge sys_clk) begin
    valid_q <= cmd.cmd_valid;
    cmd_q   <= cmd.cmd_word;
    data_q  <= cmd.data_word;
  end

  // Classify the held command: undefined opcodes and out-of-range channel writes are rejected
  always_comb begin
    reject = 1'b0;
    case (opcode)
      4'h0, 4'h3, 4'h4, 4'h5: reject = 1'b0;
      4'h1, 4'h2:             reject = !ch_ok;
`ifdef CMD_ERR_CNT_EN
      4'h6:                   reject = 1'b0;
`endif
      default:                reject = 1'b1;
    endcase
  end

  // Command FSM with registered shadow/active state and single-cycle pulses
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= WAIT_LOW;
      hold_cmd      <= '0;
      hold_data     <= '0;
      sh_phase      <= '0;
      sh_amp        <= '0;
      sh_wave       <= '0;
      ch_phase_inc  <= '0;
      ch_amp        <= '0;
      ch_wave       <= '0;
      ch_enable     <= '0;
      phase_rst     <= '0;
      update_strobe <= 1'b0;
`ifdef CMD_ERR_CNT_EN
      err_cnt       <= '0;
`endif
    end else begin
      phase_rst     <= '0;
      update_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_q) begin
            hold_cmd  <= cmd_q;
            hold_data <= data_q;
            state     <= EXEC;
          end
        end
        EXEC: begin
          state <= WAIT_LOW;
          if (reject) begin
`ifdef CMD_ERR_CNT_EN
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
          end else begin
            case (opcode)
              4'h1: begin
                for (int n = 0; n < NUM_CH; n++)
                  if (ch == 4'(n)) sh_phase[n*DATA_WIDTH +: DATA_WIDTH] <= hold_data;
              end
              4'h2: begin
                for (int n = 0; n < NUM_CH; n++)
                  if (ch == 4'(n)) begin
                    sh_amp[n*8 +: 8]  <= hold_data[7:0];
                    sh_wave[n*2 +: 2] <= hold_data[9:8];
                  end
              end
              4'h3: ch_enable <= hold_data[NUM_CH-1:0];
              4'h4: begin
                ch_phase_inc  <= sh_phase;
                ch_amp        <= sh_amp;
                ch_wave       <= sh_wave;
                update_strobe <= 1'b1;
              end
              4'h5: phase_rst <= hold_data[NUM_CH-1:0];
`ifdef CMD_ERR_CNT_EN
              4'h6: err_cnt <= '0;
`endif
              default: ;
            endcase
          end
        end
        WAIT_LOW: begin
          if (!valid_q) state <= IDLE;
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [63:0] ch_phase_inc;
  logic [31:0] ch_amp;
  logic [7:0]  ch_wave;
  logic [3:0]  ch_enable;
  logic [3:0]  phase_rst;
  logic        update_strobe;
`ifdef CMD_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  spi_cmd_ctrl_if #(.DATA_WIDTH(16)) cmd_if ();

  spi_cmd_ctrl #(.NUM_CH(4), .DATA_WIDTH(16)) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .cmd           (cmd_if),
    .ch_phase_inc  (ch_phase_inc),
    .ch_amp        (ch_amp),
    .ch_wave       (ch_wave),
    .ch_enable     (ch_enable),
    .phase_rst     (phase_rst),
    .update_strobe (update_strobe)
`ifdef CMD_ERR_CNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // One complete command: valid high 4 cycles, then low long enough to return to IDLE
  task automatic issue(input logic [7:0] c, input logic [15:0] d);
    @(negedge sys_clk);
    cmd_if.cmd_word  = c;
    cmd_if.data_word = d;
    cmd_if.cmd_valid = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    cmd_if.cmd_word  = 8'h00;
    cmd_if.data_word = 16'h0000;
    cmd_if.cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (ch_phase_inc !== 64'h0) begin errors++; $display("FAIL reset_phase_inc: got %h expected %h", ch_phase_inc, 64'h0); end
    checks++; if (ch_amp !== 32'h0) begin errors++; $display("FAIL reset_amp: got %h expected %h", ch_amp, 32'h0); end
    checks++; if (ch_wave !== 8'h0) begin errors++; $display("FAIL reset_wave: got %h expected %h", ch_wave, 8'h0); end
    checks++; if (ch_enable !== 4'h0) begin errors++; $display("FAIL reset_enable: got %h expected %h", ch_enable, 4'h0); end
    checks++; if (phase_rst !== 4'h0) begin errors++; $display("FAIL reset_phase_rst: got %h expected %h", phase_rst, 4'h0); end
    checks++; if (update_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected %b", update_strobe, 1'b0); end
`ifdef CMD_ERR_CNT_EN
    checks++; if (err_cnt !== 8'h0) begin errors++; $display("FAIL reset_err_cnt: got %h expected %h", err_cnt, 8'h0); end
`endif
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_shadow_commit();
    int hits;
    issue(8'h12, 16'h1234);
    checks++; if (ch_phase_inc !== 64'h0) begin errors++; $display("FAIL shadow_hidden: got %h expected %h", ch_phase_inc, 64'h0); end
    hits = 0;
    @(negedge sys_clk);
    cmd_if.cmd_word  = 8'h40;
    cmd_if.data_word = 16'h0000;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (update_strobe === 1'b1) hits++;
      checks++;
      if (update_strobe !== (i == 2)) begin errors++; $display("FAIL commit_strobe_c%0d: got %b expected %b", i, update_strobe, (i == 2)); end
      checks++;
      if (ch_phase_inc !== ((i >= 2) ? 64'h0000_1234_0000_0000 : 64'h0)) begin
        errors++; $display("FAIL commit_phase_c%0d: got %h expected %h", i, ch_phase_inc, ((i >= 2) ? 64'h0000_1234_0000_0000 : 64'h0));
      end
    end
    checks++; if (hits != 1) begin errors++; $display("FAIL commit_strobe_count: got %0d expected %0d", hits, 1); end
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_phase_rst();
    @(negedge sys_clk);
    cmd_if.cmd_word  = 8'h50;
    cmd_if.data_word = 16'h0005;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (phase_rst !== ((i == 2) ? 4'b0101 : 4'b0000)) begin
        errors++; $display("FAIL phase_rst_c%0d: got %b expected %b", i, phase_rst, ((i == 2) ? 4'b0101 : 4'b0000));
      end
    end
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
    checks++; if (ch_phase_inc !== 64'h0000_1234_0000_0000) begin errors++; $display("FAIL phase_rst_no_side: got %h expected %h", ch_phase_inc, 64'h0000_1234_0000_0000); end
  endtask

  task automatic test_reject();
    issue(8'h17, 16'hBEEF);
`ifdef CMD_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt_one: got %0d expected %0d", err_cnt, 1); end
`endif
    issue(8'h70, 16'hFFFF);
    issue(8'h2F, 16'h03FF);
`ifdef CMD_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL err_cnt_three: got %0d expected %0d", err_cnt, 3); end
`else
    issue(8'h60, 16'h000F);
    checks++; if (ch_enable !== 4'h0) begin errors++; $display("FAIL op6_undefined: got %h expected %h", ch_enable, 4'h0); end
`endif
    issue(8'h40, 16'h0000);
    checks++; if (ch_phase_inc !== 64'h0000_1234_0000_0000) begin errors++; $display("FAIL reject_phase: got %h expected %h", ch_phase_inc, 64'h0000_1234_0000_0000); end
    checks++; if (ch_amp !== 32'h0) begin errors++; $display("FAIL reject_amp: got %h expected %h", ch_amp, 32'h0); end
    checks++; if (ch_wave !== 8'h0) begin errors++; $display("FAIL reject_wave: got %h expected %h", ch_wave, 8'h0); end
`ifdef CMD_ERR_CNT_EN
    issue(8'h60, 16'h0000);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_clear: got %0d expected %0d", err_cnt, 0); end
    for (int i = 0; i < 300; i++) issue(8'h17, 16'h0000);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_saturate: got %0d expected %0d", err_cnt, 255); end
    issue(8'h60, 16'h0000);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_clear2: got %0d expected %0d", err_cnt, 0); end
`endif
  endtask

  task automatic test_amp_wave();
    issue(8'h21, 16'h03A5);
    checks++; if (ch_amp !== 32'h0) begin errors++; $display("FAIL amp_shadow_hidden: got %h expected %h", ch_amp, 32'h0); end
    issue(8'h40, 16'h0000);
    checks++; if (ch_amp !== 32'h0000_A500) begin errors++; $display("FAIL amp_commit: got %h expected %h", ch_amp, 32'h0000_A500); end
    checks++; if (ch_wave !== 8'b0000_1100) begin errors++; $display("FAIL wave_commit: got %b expected %b", ch_wave, 8'b0000_1100); end
    checks++; if (ch_phase_inc !== 64'h0000_1234_0000_0000) begin errors++; $display("FAIL amp_keeps_phase: got %h expected %h", ch_phase_inc, 64'h0000_1234_0000_0000); end
  endtask

  task automatic test_reset_mid_cmd();
    issue(8'h30, 16'h0003);
    checks++; if (ch_enable !== 4'h3) begin errors++; $display("FAIL enable_set: got %h expected %h", ch_enable, 4'h3); end
    @(negedge sys_clk);
    cmd_if.cmd_word  = 8'h30;
    cmd_if.data_word = 16'h000F;
    cmd_if.cmd_valid = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    checks++; if (ch_phase_inc !== 64'h0) begin errors++; $display("FAIL midrst_phase: got %h expected %h", ch_phase_inc, 64'h0); end
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      checks++;
      if (ch_enable !== 4'h0) begin errors++; $display("FAIL midrst_enable_c%0d: got %h expected %h", i, ch_enable, 4'h0); end
    end
    cmd_if.cmd_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    checks++; if (ch_enable !== 4'h0) begin errors++; $display("FAIL midrst_enable_low: got %h expected %h", ch_enable, 4'h0); end
    issue(8'h30, 16'h000F);
    checks++; if (ch_enable !== 4'hF) begin errors++; $display("FAIL midrst_enable_new: got %h expected %h", ch_enable, 4'hF); end
  endtask

  task automatic test_back_to_back();
    issue(8'h11, 16'h0AAA);
    issue(8'h13, 16'h0BBB);
    issue(8'h10, 16'h0CCC);
    issue(8'h40, 16'h0000);
    checks++; if (ch_phase_inc !== 64'h0BBB_0000_0AAA_0CCC) begin errors++; $display("FAIL b2b_phase: got %h expected %h", ch_phase_inc, 64'h0BBB_0000_0AAA_0CCC); end
    issue(8'h40, 16'h0000);
    checks++; if (ch_phase_inc !== 64'h0BBB_0000_0AAA_0CCC) begin errors++; $display("FAIL b2b_recommit: got %h expected %h", ch_phase_inc, 64'h0BBB_0000_0AAA_0CCC); end
    issue(8'h00, 16'hFFFF);
    checks++; if (ch_enable !== 4'hF) begin errors++; $display("FAIL nop_enable: got %h expected %h", ch_enable, 4'hF); end
  endtask

  initial begin
    test_reset();
    test_shadow_commit();
    test_phase_rst();
    test_reject();
    test_amp_wave();
    test_reset_mid_cmd();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
